spike_rate_decoder: RTL
=======================

Name: spike_rate_decoder

Overview:
- Decodes single-cycle spike trains from a bank of LIF neurons back into 8-bit rate values; the receiving end of the neuron spike interface.
- Counts spikes per channel over a fixed window of clock cycles, then presents a snapshot of all channel counts on a valid/ready output port.
- Sits after the neuron array, alongside the uio spike outputs. It feeds monitoring logic or the next layer's Isyn inputs.

Parameters:
- NUM_CH, 3, number of spike channels.
- WIN_LEN, 256, window length in clock cycles, at least 2.
- CNT_W, 8, per-channel count width; counts saturate at 2^CNT_W-1.
- LEAK_SHIFT, 3, decay shift for the optional synaptic trace.
- WEIGHT, 32, trace increment per spike for the optional synaptic trace.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  window enable.
- spike  in  NUM_CH  spike inputs; a 1 sampled in a cycle counts as one spike.
- out_valid  out  1  snapshot available.
- out_ready  in  1  consumer accepts the snapshot.
- out_data  out  NUM_CH*CNT_W  snapshot; channel i is at bits [i*CNT_W +: CNT_W].
- overrun  out  1  sticky flag: a snapshot was dropped.
- clr_overrun  in  1  clears overrun.
- isyn_out  out  NUM_CH*8  synaptic trace (present only with the optional feature).

Behaviour:
- Reset, synchronous and active-high, dominates every other input in the same cycle:
  - win_cnt, all channel counters, out_data, out_valid, overrun and isyn_out all become 0.
- FSM has 2 states, IDLE and COUNT; reset state is IDLE.
  - IDLE: win_cnt=0 and counters=0. If en=1, go to COUNT; that cycle's spikes are not counted.
  - COUNT: if en=0, go to IDLE and clear win_cnt and counters; the partial window is discarded. A pending out_valid/out_data is kept.
- In COUNT, each cycle:
  - cnt[i] <= sat(cnt[i] + spike[i]), saturating, with no wrap.
  - win_cnt increments.
- Window end: COUNT with win_cnt == WIN_LEN-1.
  - Snapshot = sat(cnt[i] + spike[i]), so the last cycle's spike is included.
  - Counters and win_cnt load 0, and the next cycle starts a new window with no gap.
- Snapshot load:
  - If out_valid=0, or out_valid&&out_ready in the same cycle: out_data <= snapshot and out_valid <= 1 on the next cycle. Latency from the last window cycle is 1.
  - If out_valid=1 and out_ready=0: the snapshot is dropped, out_data is unchanged, and overrun <= 1.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - out_data is stable while out_valid=1.
  - out_valid falls the cycle after a transfer unless a new snapshot loads in that cycle.
  - out_ready has no effect when out_valid=0.
- overrun:
  - Set takes priority over clr_overrun in the same cycle.
  - Otherwise clr_overrun=1 clears it next cycle.

Optional Feature:
- Macro: SPIKE_DEC_TRACE_EN.
- Defined:
  - The isyn_out port exists, with one 8-bit trace per channel, updated every cycle regardless of en.
  - trace <= sat255(trace - (trace >> LEAK_SHIFT) + (spike[i] ? WEIGHT : 0)).
  - Reset sets trace to 0.
  - The trace output is suitable as a downstream LIF Isyn.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package spike_dec_pkg:
  - state enum (IDLE, COUNT);
  - sat_add function;
  - default WIN_LEN and CNT_W constants.
- Sub-module spike_chan_counter, instantiated NUM_CH times:
  - saturating counter, with clear and window-end snapshot output;
  - also holds the trace register when SPIKE_DEC_TRACE_EN is defined.

Test Plan:
- Basic count:
  - Stimulus: rst, then en=1, WIN_LEN=8, out_ready=1; ch0 spikes every cycle, ch1 every 2nd cycle, ch2 never.
  - Response: out_valid pulses once per 8 cycles with out_data ch0=8, ch1=4, ch2=0.
- Saturation:
  - Stimulus: CNT_W=3, WIN_LEN=16, spike[0] held high.
  - Response: ch0 snapshot = 7, never wraps to 0.
- Backpressure:
  - Stimulus: out_ready=0 across 2 window ends.
  - Response: first snapshot held stable, second dropped, overrun=1.
  - Then: out_ready=1 transfers the first snapshot; clr_overrun clears overrun.
- Simultaneous transfer and snapshot:
  - Stimulus: out_ready=1 exactly on the window-end cycle while out_valid=1.
  - Response: new snapshot loads, out_valid stays 1, overrun stays 0.
- Enable drop and mid-window reset:
  - Stimulus: en=0 at win_cnt=5.
  - Response: counters clear; the next window starts 1 cycle after en returns to 1 and gives a full WIN_LEN count.
  - Stimulus: rst asserted at win_cnt=3 with out_valid=1.
  - Response: all outputs 0 next cycle.
- Trace (SPIKE_DEC_TRACE_EN defined, WEIGHT=32, LEAK_SHIFT=3):
  - Stimulus: single spike.
  - Response: isyn_out ch0 = 32, then 28, then 25, then 22.
  - Stimulus: continuous spikes.
  - Response: trace saturates at 255.

Source files
------------

// File: rtl/spike_dec_pkg.sv
// Shared types, defaults and the saturating adder for the spike rate decoder.
// Used by spike_rate_decoder and spike_chan_counter.
package spike_dec_pkg;

    localparam int DEF_WIN_LEN = 256;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Unsigned add that clamps at max_val instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Valid/ready snapshot port of the spike rate decoder.
// The decoder drives it through the master modport; the consumer uses slave.
interface spike_rate_decoder_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8
);
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_CH*CNT_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/spike_chan_counter.sv
// One spike channel: saturating window counter with a combinational end-of-window value.
// With SPIKE_DEC_TRACE_EN defined it also carries a leaky 8-bit synaptic trace.
module spike_chan_counter
    import spike_dec_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
`ifdef SPIKE_DEC_TRACE_EN
    ,
    parameter int LEAK_SHIFT = 3,
    parameter int WEIGHT     = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike,
    input  logic             clear,
    output logic [CNT_W-1:0] snap
`ifdef SPIKE_DEC_TRACE_EN
    ,
    output logic [7:0]       trace
`endif
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] cnt;

    // snap is the count including this cycle's spike, so the last window cycle is not lost.
    assign snap = CNT_W'(sat_add(32'(cnt), {31'd0, spike}, CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else begin
            cnt <= snap;
        end
    end

`ifdef SPIKE_DEC_TRACE_EN
    logic [7:0] trace_dec;

    assign trace_dec = trace - (trace >> LEAK_SHIFT);

    // The trace runs every cycle, independent of the counting window.
    always_ff @(posedge clk) begin
        if (rst) begin
            trace <= '0;
        end else begin
            trace <= 8'(sat_add(32'(trace_dec), spike ? 32'(WEIGHT) : 32'd0, 32'd255));
        end
    end
`endif

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per channel over WIN_LEN-cycle windows and offers each window's counts on a valid/ready port.
// Optional synaptic trace output isyn_out is built when SPIKE_DEC_TRACE_EN is defined.
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int WIN_LEN    = DEF_WIN_LEN,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LEAK_SHIFT = 3,
    parameter int WEIGHT     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       spike,
    spike_rate_decoder_if.master    out_port,
    output logic                    overrun,
    input  logic                    clr_overrun
`ifdef SPIKE_DEC_TRACE_EN
    ,
    output logic [NUM_CH*8-1:0]     isyn_out
`endif
);

    localparam int              WIN_W    = $clog2(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    if (WIN_LEN < 2 || CNT_W < 1 || CNT_W > 31 || LEAK_SHIFT < 0 || LEAK_SHIFT > 7
        || WEIGHT < 0 || WEIGHT > 255) begin : g_bad_param
        $error("spike_rate_decoder: parameter out of range");
    end

    state_t                  state;
    logic [WIN_W-1:0]        win_cnt;
    logic                    count_run;
    logic                    win_end;
    logic                    ctr_clear;
    logic                    load;
    logic                    drop;
    logic [NUM_CH*CNT_W-1:0] snapshot;

    assign count_run = (state == COUNT) && en;
    assign win_end   = count_run && (win_cnt == WIN_LAST);
    // Counters hold zero outside a running window and restart at each window end.
    assign ctr_clear = !count_run || win_end;
    assign load      = win_end && (!out_port.out_valid || out_port.out_ready);
    assign drop      = win_end && out_port.out_valid && !out_port.out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            win_cnt <= '0;
        end else if (state == IDLE) begin
            win_cnt <= '0;
            if (en) begin
                state <= COUNT;
            end
        end else if (!en) begin
            state   <= IDLE;
            win_cnt <= '0;
        end else if (win_end) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        spike_chan_counter #(
            .CNT_W      (CNT_W)
`ifdef SPIKE_DEC_TRACE_EN
            ,
            .LEAK_SHIFT (LEAK_SHIFT),
            .WEIGHT     (WEIGHT)
`endif
        ) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .spike (spike[i]),
            .clear (ctr_clear),
            .snap  (snapshot[i*CNT_W +: CNT_W])
`ifdef SPIKE_DEC_TRACE_EN
            ,
            .trace (isyn_out[i*8 +: 8])
`endif
        );
    end

    // NOTE: out_data is reset along with the control flops so the port reads a defined 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_port.out_valid <= 1'b0;
            out_port.out_data  <= '0;
            overrun            <= 1'b0;
        end else begin
            if (load) begin
                out_port.out_data  <= snapshot;
                out_port.out_valid <= 1'b1;
            end else if (out_port.out_valid && out_port.out_ready) begin
                out_port.out_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear request leaves the flag set.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
